// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared RV32I pipeline constants and the fetch FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0, x0, 0

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // free to issue a request
        WAIT  = 2'd1,   // one request outstanding
        HOLD  = 2'd2,   // response parked while decode is stalled
        KILL  = 2'd3    // outstanding response belongs to a squashed path
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Instruction-memory request/response bus between the fetch
//               stage (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with write enable and a synchronous
//               flush that takes priority over the enable.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import riscv_pkg::*;
(
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_we,
    input  wire logic            i_flush,
    input  wire logic [XLEN-1:0] i_pc,
    input  wire logic [XLEN-1:0] i_instr,
    input  wire logic            i_valid,
    output logic      [XLEN-1:0] o_pc,
    output logic      [XLEN-1:0] o_instr,
    output logic                 o_valid
);

    // Flush turns the slot into a NOP bubble but keeps the PC as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pc    <= '0;
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            o_instr <= NOP_INSTR;
            o_valid <= 1'b0;
        end else if (i_we) begin
            o_pc    <= i_pc;
            o_instr <= i_instr;
            o_valid <= i_valid;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : RV32I instruction-fetch stage. Owns the PC, keeps a single
//               instruction-memory request outstanding and loads IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            pc_write,
    input  wire logic            if_id_write,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    if_stage_if.master           imem,
    output logic      [XLEN-1:0] if_id_pc,
    output logic      [XLEN-1:0] if_id_instr,
    output logic                 if_id_valid
);

    fetch_state_t    r_state;
    fetch_state_t    w_next_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_hold_instr;

    logic            w_req;
    logic            w_accept;
    logic            w_capture;
    logic [XLEN-1:0] w_redirect_target;

    logic            w_idr_we;
    logic [XLEN-1:0] w_idr_pc;
    logic [XLEN-1:0] w_idr_instr;
    logic            w_idr_valid;

    // Gated by rst so no request leaks out while reset is asserted.
    assign w_req             = (r_state == FETCH) && pc_write && !redirect_valid && !rst;
    assign w_accept          = w_req && imem.imem_ready;
    assign w_redirect_target = redirect_pc & ~32'h0000_0003;

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;

    // Fetch FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and IF/ID load control; redirect overrides everything.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_idr_we     = 1'b0;
        w_idr_pc     = if_id_pc;      // bubbles keep the old PC
        w_idr_instr  = NOP_INSTR;
        w_idr_valid  = 1'b0;

        if (redirect_valid) begin
            // A still-outstanding response must be swallowed in KILL.
            w_next_state = (r_state == WAIT && !imem.imem_rvalid) ? KILL : FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    w_idr_we = if_id_write;
                    if (w_accept) begin
                        w_next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (if_id_write) begin
                            w_idr_we     = 1'b1;
                            w_idr_pc     = r_req_pc;
                            w_idr_instr  = imem.imem_rdata;
                            w_idr_valid  = 1'b1;
                            w_next_state = FETCH;
                        end else begin
                            w_capture    = 1'b1;
                            w_next_state = HOLD;
                        end
                    end else begin
                        w_idr_we = if_id_write;
                    end
                end
                HOLD: begin
                    // r_req_pc cannot change here since no request is issued.
                    if (if_id_write) begin
                        w_idr_we     = 1'b1;
                        w_idr_pc     = r_req_pc;
                        w_idr_instr  = r_hold_instr;
                        w_idr_valid  = 1'b1;
                        w_next_state = FETCH;
                    end
                end
                KILL: begin
                    w_idr_we = if_id_write;
                    if (imem.imem_rvalid) begin
                        w_next_state = FETCH;
                    end
                end
                default: begin
                    w_next_state = FETCH;
                end
            endcase
        end
    end

    // PC, in-flight request address and the one-entry hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= RESET_PC;
            r_hold_instr <= NOP_INSTR;
        end else if (redirect_valid) begin
            r_pc         <= w_redirect_target;
            r_hold_instr <= NOP_INSTR;
        end else begin
            if (w_accept) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + 32'd4;
            end
            if (w_capture) begin
                r_hold_instr <= imem.imem_rdata;
            end
        end
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_idr_we),
        .i_flush (redirect_valid),
        .i_pc    (w_idr_pc),
        .i_instr (w_idr_instr),
        .i_valid (w_idr_valid),
        .o_pc    (if_id_pc),
        .o_instr (if_id_instr),
        .o_valid (if_id_valid)
    );

endmodule
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC, issues single-outstanding requests to instruction memory, and loads the IF/ID pipeline register. It consumes `pc_write` and `if_id_write` from the hazard unit and the EX-stage branch/jump redirect. It feeds `if_id_pc`, `if_id_instr` and `if_id_valid` to decode.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pc_write` in 1: 0 suppresses issuing a new fetch and holds the PC.
- `if_id_write` in 1: 0 holds the IF/ID register.
- `redirect_valid` in 1: branch/jump taken in EX; flush and redirect.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, equal to the current PC.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: instruction word.
- `if_id_pc` out 32: PC of the instruction held in IF/ID.
- `if_id_instr` out 32: instruction held in IF/ID.
- `if_id_valid` out 1: IF/ID holds a real instruction.

## Operation

FSM states: FETCH, WAIT, HOLD, KILL.

- **Request:** `imem_req = (state==FETCH) && pc_write && !redirect_valid`.
- **Accept:** a request is accepted when `imem_req && imem_ready`. On acceptance, latch `req_pc = pc`, set `pc <= pc+4` (mod 2^32, wraps silently), and go to WAIT.
- **WAIT, `imem_rvalid`:**
  - If `if_id_write`=1: load IF/ID (`req_pc`, `imem_rdata`, valid=1) and go to FETCH.
  - Otherwise: capture into a 1-entry hold buffer and go to HOLD.
- **HOLD:** no request is issued. When `if_id_write`=1, move the buffer into IF/ID (valid=1) and go to FETCH.
- **KILL:** no request is issued. On `imem_rvalid`, drop the response and go to FETCH.
- **Bubble:** in FETCH, or in WAIT without `imem_rvalid`, with `if_id_write`=1, IF/ID loads `if_id_valid`=0, `if_id_instr`=NOP (32'h0000_0013), and `if_id_pc` unchanged.
- **Redirect** (highest priority, any state):
  - `pc <= {redirect_pc[31:2],2'b00}`.
  - `if_id_valid <= 0` and `if_id_instr <= NOP`; this flush overrides `if_id_write`=0.
  - The hold buffer is cleared.
  - Next state: WAIT without `imem_rvalid` goes to KILL. Every other case goes to FETCH, including WAIT with `imem_rvalid` in the same cycle, where the response is dropped.
- Responses arriving in FETCH or HOLD are protocol violations. They are ignored; the bench asserts they never occur.

## Timing

- **Reset values:**
  - `pc`=RESET_PC, state=FETCH.
  - `imem_req`=0 while `rst` is high.
  - `if_id_valid`=0, `if_id_instr`=NOP, `if_id_pc`=0.
  - Hold buffer empty.
- **After reset:** `imem_req` may assert in the first cycle after `rst` falls.
- **Reset mid-transaction:** returns to the reset values. Memory must not deliver a response for a request issued before reset.
- **Latency:** with `imem_ready`=1 and `imem_rvalid` one cycle after acceptance:
  - Request at cycle N, response at N+1.
  - IF/ID is valid after the N+1 edge.
  - The next request issues at N+2.
  - Throughput is therefore 1 instruction per 2 cycles (single outstanding).
- **Outputs:** IF/ID outputs are registered. `imem_addr` is `pc` (registered). `imem_req` is combinational from state, `pc_write` and `redirect_valid`.
- **`pc_write`=0 in FETCH:** no request, PC holds. `pc_write` has no effect in WAIT, HOLD or KILL.

## Structure

- Shared package `riscv_pkg`:
  - `XLEN`=32.
  - `NOP_INSTR`=32'h0000_0013.
  - `fetch_state_t` enum {FETCH, WAIT, HOLD, KILL}.
- One sub-module, `if_id_reg`: an IF/ID register with write-enable and synchronous flush (flush wins), async reset to valid=0 / NOP / PC 0.
- FSM, PC, `req_pc` and hold buffer live in `if_stage`.

## Test plan

- **Reset and first fetch:** reset with RESET_PC=32'h100, `imem_ready`=1, one-cycle response `rdata`=32'h0010_0093 → `imem_addr`=0x100 first cycle after reset; `if_id_pc`=0x100, `if_id_instr`=0x00100093, `if_id_valid`=1 two edges later; next `imem_addr`=0x104.
- **Load-use stall:** hold `if_id_write`=0 and `pc_write`=0 while response 0xAAAA_AAAA arrives → state HOLD, IF/ID unchanged, no `imem_req`; release → IF/ID gets 0xAAAAAAAA; request resumes at the next PC.
- **Redirect during WAIT:** `redirect_valid`=1 with `redirect_pc`=0x203 while a fetch of 0x104 is outstanding → KILL. The following response is dropped (`if_id_valid` stays 0), then `imem_addr`=0x200.
- **Redirect coincident with `imem_rvalid` and `if_id_write`=0:** `if_id_valid`=0 next cycle (flush beats hold), response dropped, next request to the target.
- **Slow memory:** `imem_ready` low 3 cycles, then `imem_rvalid` delayed 4 cycles → `imem_req`/`imem_addr` stable throughout; exactly one IF/ID load; bubbles (valid=0, NOP) meanwhile.
- **PC wrap:** RESET_PC=32'hFFFF_FFFC → second request address is 0x0000_0000.
